// File: rtl/wb_stage_if.sv
// Writeback stage bus: ALU and load producer handshakes plus the regfile write port.
// Latency: none (signal bundle only).
// Backpressure: alu_ready / ld_ready are driven by the stage; producers hold valid until accepted.
// Optional macro WB_FWD_EN adds the forwarding outputs fwd_valid/fwd_rd/fwd_data.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_word;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;

  logic            wr_en;
  logic [4:0]      w1;
  logic [XLEN-1:0] data;
  logic            busy;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  // Producer / observer side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_word, ld_funct3, ld_addr_lo,
    input  alu_ready, ld_ready, wr_en, w1, data, busy
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );

  // Writeback stage side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_word, ld_funct3, ld_addr_lo,
    output alu_ready, ld_ready, wr_en, w1, data, busy
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and load results onto one registered regfile write per cycle.
// Latency: a result accepted at edge N is written during cycle N+1; a skid-held ALU result waits.
// Backpressure: alu_ready=0 while the skid holds; ld_ready=0 only when the held result has starved.
// Optional macro WB_FWD_EN adds combinational forwarding copies of the write port.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  wb
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } skid_state_t;

  skid_state_t     state;
  logic [3:0]      starve_cnt;
  logic [4:0]      skid_rd;
  logic [XLEN-1:0] skid_data;

  logic            wr_en_q;
  logic [4:0]      w1_q;
  logic [XLEN-1:0] data_q;

  logic            ld_ready_c;
  logic            ld_win;
  logic            alu_fire;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // A held result that has lost STARVE_MAX times in a row blocks the load port for one cycle.
  assign ld_ready_c = !((state == HELD) && (starve_cnt == STARVE_LIM));
  assign ld_win     = wb.ld_valid && ld_ready_c;
  assign alu_fire   = wb.alu_valid && (state == EMPTY);

  // Select the addressed byte/halfword and extend it according to the load type.
  always_comb begin
    ld_byte = wb.ld_word[7:0];
    ld_half = wb.ld_word[15:0];
    ld_ext  = wb.ld_word;
    case (wb.ld_addr_lo)
      2'd0:    ld_byte = wb.ld_word[7:0];
      2'd1:    ld_byte = wb.ld_word[15:8];
      2'd2:    ld_byte = wb.ld_word[23:16];
      default: ld_byte = wb.ld_word[31:24];
    endcase
    ld_half = wb.ld_addr_lo[1] ? wb.ld_word[31:16] : wb.ld_word[15:0];
    case (wb.ld_funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = wb.ld_word;
    endcase
  end

  // Skid FSM, starve counter and registered write port; load > skid > direct ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      starve_cnt <= 4'd0;
      skid_rd    <= 5'd0;
      skid_data  <= '0;
      wr_en_q    <= 1'b0;
      w1_q       <= 5'd0;
      data_q     <= '0;
    end else begin
      if (ld_win) begin
        wr_en_q <= (wb.ld_rd != 5'd0);
        w1_q    <= wb.ld_rd;
        data_q  <= ld_ext;
        if (alu_fire) begin
          state     <= HELD;
          skid_rd   <= wb.alu_rd;
          skid_data <= wb.alu_data;
        end
      end else if (state == HELD) begin
        wr_en_q <= (skid_rd != 5'd0);
        w1_q    <= skid_rd;
        data_q  <= skid_data;
        state   <= EMPTY;
      end else if (alu_fire) begin
        wr_en_q <= (wb.alu_rd != 5'd0);
        w1_q    <= wb.alu_rd;
        data_q  <= wb.alu_data;
      end else begin
        wr_en_q <= 1'b0;
      end

      // Count only losses suffered while holding; any drain or empty cycle resets the count.
      if ((state == HELD) && ld_win) begin
        if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  assign wb.alu_ready = (state == EMPTY);
  assign wb.ld_ready  = ld_ready_c;
  assign wb.busy      = (state == HELD);
  assign wb.wr_en     = wr_en_q;
  assign wb.w1        = w1_q;
  assign wb.data      = data_q;

`ifdef WB_FWD_EN
  // Bypass copy of the write in flight; reset clears wr_en_q, which also clears fwd_valid.
  assign wb.fwd_valid = wr_en_q && (w1_q != 5'd0);
  assign wb.fwd_rd    = w1_q;
  assign wb.fwd_data  = data_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that sits directly upstream of the register file and drives its single write port (`wr_en`, `w1`, `data`). It accepts results from two producers each cycle: the ALU and the multi-cycle load unit. It extends load data per the load type and arbitrates the two producers onto one registered write per cycle. A one-entry skid buffer holds the ALU result when a load wins arbitration, and a starvation counter guarantees the ALU result eventually drains.

## Interface
- `XLEN`, 32, datapath width
- `STARVE_MAX`, 4, consecutive cycles a held ALU result may lose to loads before it is forced through (1..15)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle (= skid empty)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  load result accepted this cycle
- `ld_rd`  in  5  load destination register
- `ld_word`  in  XLEN  raw aligned memory word
- `ld_funct3`  in  3  load type
- `ld_addr_lo`  in  2  byte offset of load address
- `wr_en`  out  1  regfile write enable (registered)
- `w1`  out  5  regfile write index (registered)
- `data`  out  XLEN  regfile write data (registered)
- `busy`  out  1  skid holds a result

## Operation
- Skid FSM states:
  - EMPTY: `alu_ready`=1.
  - HELD: `alu_ready`=0; holds rd and data.
- Write-source priority each cycle:
  - If `ld_ready && ld_valid`, the load is written.
  - Otherwise, if HELD, the skid is written and the FSM goes to EMPTY.
  - Otherwise, if `alu_valid`, the ALU result is written directly.
- ALU accepted while EMPTY and the load also wins that cycle: the ALU result is captured into the skid (EMPTY→HELD).
- HELD and a new ALU result in the same cycle: impossible (`alu_ready`=0).
- Skid draining to EMPTY in a cycle: `alu_ready` does not rise until the following cycle.
- `ld_ready`=1, except when HELD and the starve counter equals `STARVE_MAX`. In that case `ld_ready`=0 and the skid is written.
- Starve counter:
  - Increments each cycle the FSM is HELD and a load wins.
  - Clears when the skid is written or the FSM is EMPTY.
  - Saturates at `STARVE_MAX`.
- Load extension by `ld_funct3`:
  - 000 LB: byte `ld_addr_lo`, sign-extended.
  - 001 LH: halfword `ld_addr_lo[1]`, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: halfword, zero-extended.
  - Any other code: treated as LW.
- Writes to rd=0 complete the handshake normally, but `wr_en` stays 0 that cycle and `w1`/`data` still update.
- No selected source: `wr_en`=0; `w1` and `data` hold their previous values.

## Timing
- Result accepted at rising edge N:
  - `wr_en`/`w1`/`data` are valid during cycle N+1.
  - The regfile commits at the edge ending cycle N+1.
- Skid-held result is written in the first cycle no load wins, or the cycle the counter reaches `STARVE_MAX`.
- Reset (`rst`=0, any time, immediate):
  - `wr_en`=0, `w1`=0, `data`=0.
  - FSM EMPTY, starve counter 0, `busy`=0.
  - `alu_ready`=1, `ld_ready`=1.
  - A held or in-flight result is discarded, with no partial write.
- After deassertion, the first acceptance is at the next rising edge.

## Configuration
- `WB_FWD_EN` defined:
  - Adds outputs `fwd_valid` (1), `fwd_rd` (5), `fwd_data` (XLEN).
  - They mirror `wr_en`/`w1`/`data` combinationally, so decode can bypass the write in flight during the cycle before the regfile commits.
  - `fwd_valid` is 0 when `w1`=0 and during reset.
- `WB_FWD_EN` undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- ALU only:
  - Stimulus: `alu_valid`=1, rd=5, data=0x12345678 at edge N.
  - Required: `wr_en`=1, `w1`=5, `data`=0x12345678 in cycle N+1; `alu_ready` stays 1.
- Simultaneous:
  - Stimulus: LW rd=3 word 0xCAFEF00D and ALU rd=7 0x1 in the same cycle.
  - Required: cycle N+1 writes x3=0xCAFEF00D with `busy`=1 and `alu_ready`=0; cycle N+2 writes x7=0x1, `busy`=0.
- Load extension, word 0x80FF7F01:
  - LB off 3 → 0xFFFFFF80.
  - LBU off 1 → 0x0000007F.
  - LH off 2 → 0xFFFF80FF.
  - LHU off 0 → 0x00007F01.
  - funct3=011 → 0x80FF7F01.
- Starvation, `STARVE_MAX`=4:
  - Stimulus: skid HELD; `ld_valid`=1 continuously.
  - Required: 4 load writes, then `ld_ready`=0 for one cycle and the skid is written; loads resume the next cycle.
- x0 plus reset:
  - Stimulus: ALU rd=0 data 0xFFFFFFFF.
  - Required: handshake completes and `wr_en`=0.
  - Stimulus: assert `rst`=0 mid-cycle while HELD.
  - Required: outputs immediately 0, `busy`=0, and no write ever issued for the discarded entry.
- With `WB_FWD_EN`: in the simultaneous case, `fwd_valid`=1, `fwd_rd`=3, `fwd_data`=0xCAFEF00D during cycle N+1.
